// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a small FIFO feeds a frame serialiser
// (start, LSB-first data, optional parity, stop bits) driving a registered line.
module uart_tx_fifo #(
    parameter int BYTESIZES           = 8,
    parameter int BAUDRATE            = 9600,
    parameter int COUNTER_CLOCK_INPUT = 50_000_000,
    parameter int FIFO_DEPTH          = 16,
    parameter int PARITY              = 0,
    parameter int STOP_BITS           = 1
) (
    input  logic                          clock,
    input  logic                          nreset,
    input  logic                          valid_tx_in,
    input  logic [BYTESIZES-1:0]          data_tx_in,
    output logic                          ready_tx_out,
    output logic                          sdata_tx_out,
    output logic                          busy_tx_out,
    output logic [$clog2(FIFO_DEPTH):0]   count_tx_out
);

    localparam int DIV = COUNTER_CLOCK_INPUT / BAUDRATE;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int BW  = $clog2((BYTESIZES > STOP_BITS) ? BYTESIZES : STOP_BITS) + 1;

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_fifo: clock/baud ratio must be at least 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t               state;
    state_t               state_next;
    logic [BYTESIZES-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic [CW-1:0]        baud;
    logic [BW-1:0]        bit_cnt;
    logic [BYTESIZES-1:0] shift;
    logic                 par_bit;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 line_next;

    assign full         = (count == (AW+1)'(FIFO_DEPTH));
    assign push         = valid_tx_in && !full;
    assign bit_end      = (baud == CW'(DIV - 1));
    assign ready_tx_out = !full;
    assign busy_tx_out  = (state != S_IDLE);
    assign count_tx_out = count;

    // A pop on the same edge as a full-FIFO write still drops the write,
    // because push is qualified by the pre-edge full flag.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= data_tx_in;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        line_next  = 1'b1;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                line_next = 1'b0;
                if (bit_end) state_next = S_DATA;
            end
            S_DATA: begin
                line_next = shift[0];
                if (bit_end && bit_cnt == BW'(BYTESIZES - 1))
                    state_next = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: begin
                line_next = par_bit;
                if (bit_end) state_next = S_STOP;
            end
            S_STOP: begin
                if (bit_end && bit_cnt == BW'(STOP_BITS - 1)) begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        state_next = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The line is registered from the current state, so it trails the FSM by one cycle.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state        <= S_IDLE;
            sdata_tx_out <= 1'b1;
            baud         <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            par_bit      <= 1'b0;
        end else begin
            state        <= state_next;
            sdata_tx_out <= line_next;
            if (state_next != state || bit_end || state == S_IDLE)
                baud <= '0;
            else
                baud <= baud + 1'b1;
            if (state_next != state)
                bit_cnt <= '0;
            else if (bit_end)
                bit_cnt <= bit_cnt + 1'b1;
            if (pop) begin
                shift   <= mem[rd_ptr];
                par_bit <= (PARITY == 2) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
            end else if (state == S_DATA && bit_end) begin
                shift <= shift >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: table-driven single frames on three parameterisations,
// directed FIFO corner cases, and random loopback into a behavioural receiver.
module tb_uart_tx_fifo;

    localparam int DIV = 10;

    logic       clock  = 1'b0;
    logic       nreset = 1'b0;
    logic       valid [3];
    logic [7:0] data  [3];
    logic       ready [3];
    logic       line  [3];
    logic       busy  [3];
    logic [2:0] count [3];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int busy_cnt [3] = '{default: 0};
    int rx_err      = 0;

    logic [7:0] rxq [$];
    int         startq [$];
    logic       rx_active = 1'b0;
    int         rx_k = 0;
    logic [7:0] rx_sh = '0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        for (int i = 0; i < 3; i++)
            if (busy[i]) busy_cnt[i] <= busy_cnt[i] + 1;
    end

    uart_tx_fifo #(.BYTESIZES(8), .BAUDRATE(100_000), .COUNTER_CLOCK_INPUT(1_000_000),
                   .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clock(clock), .nreset(nreset), .valid_tx_in(valid[0]), .data_tx_in(data[0]),
        .ready_tx_out(ready[0]), .sdata_tx_out(line[0]), .busy_tx_out(busy[0]),
        .count_tx_out(count[0]));

    uart_tx_fifo #(.BYTESIZES(8), .BAUDRATE(100_000), .COUNTER_CLOCK_INPUT(1_000_000),
                   .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(2)) dut1 (
        .clock(clock), .nreset(nreset), .valid_tx_in(valid[1]), .data_tx_in(data[1]),
        .ready_tx_out(ready[1]), .sdata_tx_out(line[1]), .busy_tx_out(busy[1]),
        .count_tx_out(count[1]));

    uart_tx_fifo #(.BYTESIZES(8), .BAUDRATE(100_000), .COUNTER_CLOCK_INPUT(1_000_000),
                   .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clock(clock), .nreset(nreset), .valid_tx_in(valid[2]), .data_tx_in(data[2]),
        .ready_tx_out(ready[2]), .sdata_tx_out(line[2]), .busy_tx_out(busy[2]),
        .count_tx_out(count[2]));

    // Mid-bit sampling receiver for dut0: 8N1 at DIV clocks per bit.
    always @(negedge clock) begin
        if (!nreset) begin
            rx_active <= 1'b0;
        end else if (!rx_active) begin
            if (line[0] == 1'b0) begin
                rx_active <= 1'b1;
                rx_k      <= 1;
                startq.push_back(cyc);
            end
        end else begin
            rx_k <= rx_k + 1;
            if (rx_k == 5 && line[0] != 1'b0) rx_err <= rx_err + 1;
            if (rx_k >= 15 && rx_k <= 85 && rx_k % 10 == 5) rx_sh[rx_k/10 - 1] <= line[0];
            if (rx_k == 95) begin
                rx_active <= 1'b0;
                if (line[0] != 1'b1) rx_err <= rx_err + 1;
                rxq.push_back(rx_sh);
            end
        end
    end

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [11:0] frame;
        int         nbits;
        int         busy_cycles;
    } vec_t;

    vec_t vecs [8];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input int sel, input logic [7:0] b, output int acc_edge);
        int   waited = 0;
        logic took;
        valid[sel] = 1'b1;
        data[sel]  = b;
        do begin
            took = ready[sel];
            @(negedge clock);
            waited++;
        end while (!took && waited < 3000);
        valid[sel] = 1'b0;
        acc_edge   = cyc;
        if (!took) check_output("push timeout", 0, 1);
    endtask

    task automatic wait_rx(input int n);
        int w = 0;
        while (rxq.size() < n && w < 40000) begin
            @(negedge clock);
            w++;
        end
        check_output("rx frame count", rxq.size(), n);
    endtask

    // Sends one byte to an idle DUT and checks latency, every bit, glitches and busy length.
    task automatic apply_stimulus(input vec_t v);
        int   b0;
        int   w;
        int   e;
        int   glitches = 0;
        logic mid [12];
        b0 = busy_cnt[v.sel];
        push_byte(v.sel, v.data, e);
        w = 1;
        while (line[v.sel] !== 1'b0 && w < 50) begin
            @(negedge clock);
            w++;
        end
        check_output($sformatf("latency dut%0d %h", v.sel, v.data), w, 3);
        for (int k = 0; k < v.nbits * DIV; k++) begin
            if (k > 0) @(negedge clock);
            if (line[v.sel] !== v.frame[k/DIV]) glitches++;
            if (k % DIV == 5) mid[k/DIV] = line[v.sel];
        end
        for (int i = 0; i < v.nbits; i++)
            check_output($sformatf("dut%0d %h bit%0d", v.sel, v.data, i), mid[i], v.frame[i]);
        check_output($sformatf("dut%0d %h off-level samples", v.sel, v.data), glitches, 0);
        repeat (5) @(negedge clock);
        check_output($sformatf("dut%0d %h busy cycles", v.sel, v.data), busy_cnt[v.sel] - b0, v.busy_cycles);
        check_output($sformatf("dut%0d %h idle line", v.sel, v.data), line[v.sel], 1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int         e [6];
        int         ea;
        int         eb;
        int         ed;
        int         low_cnt;
        logic [7:0] sent [$];
        logic [7:0] rb;

        // Frames are LSB-first bit lists: start, data, [parity], stop(s).
        vecs[0] = '{0, 8'hA5, 12'h34A, 10, 100};
        vecs[1] = '{0, 8'h00, 12'h200, 10, 100};
        vecs[2] = '{0, 8'hFF, 12'h3FE, 10, 100};
        vecs[3] = '{0, 8'h3C, 12'h278, 10, 100};
        vecs[4] = '{1, 8'h07, 12'hE0E, 12, 120};
        vecs[5] = '{1, 8'h03, 12'hC06, 12, 120};
        vecs[6] = '{2, 8'h07, 12'h40E, 11, 110};
        vecs[7] = '{2, 8'h00, 12'h600, 11, 110};

        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0;
            data[i]  = '0;
        end
        nreset = 1'b0;
        repeat (2) @(negedge clock);
        check_output("reset line", line[0], 1);
        check_output("reset ready", ready[0], 1);
        check_output("reset busy", busy[0], 0);
        check_output("reset count", count[0], 0);
        nreset = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);

        // Burst of six with valid held: five back-to-back, sixth waits for the first queue pop.
        rxq.delete();
        startq.delete();
        for (int i = 0; i < 6; i++) begin
            push_byte(0, 8'(i), e[i]);
            if (i == 4) begin
                check_output("burst count full", count[0], 4);
                check_output("burst ready low", ready[0], 0);
            end
        end
        for (int i = 1; i < 5; i++) check_output($sformatf("burst accept %0d", i), e[i] - e[0], i);
        check_output("burst stall accept", e[5] - e[0], 102);
        wait_rx(6);
        for (int i = 0; i < 6 && i < rxq.size(); i++)
            check_output($sformatf("burst rx %0d", i), rxq[i], i);
        for (int i = 1; i < 6 && i < startq.size(); i++)
            check_output($sformatf("burst gap %0d", i), startq[i] - startq[i-1], 100);
        repeat (20) @(negedge clock);

        // Push on the same edge the FSM pops, with two bytes queued.
        rxq.delete();
        push_byte(0, 8'hA0, ea);
        push_byte(0, 8'hA1, ed);
        push_byte(0, 8'hA2, ed);
        while (cyc < ea + 100) @(negedge clock);
        check_output("pre push+pop count", count[0], 2);
        valid[0] = 1'b1;
        data[0]  = 8'hA3;
        @(negedge clock);
        valid[0] = 1'b0;
        check_output("push+pop count", count[0], 2);
        check_output("push+pop ready", ready[0], 1);
        wait_rx(4);
        for (int i = 0; i < 4 && i < rxq.size(); i++)
            check_output($sformatf("order rx %0d", i), rxq[i], 8'hA0 + 8'(i));
        repeat (20) @(negedge clock);

        // Reset 35 cycles into a frame with bytes still queued.
        rxq.delete();
        push_byte(0, 8'hB0, eb);
        push_byte(0, 8'hB1, ed);
        push_byte(0, 8'hB2, ed);
        while (cyc < eb + 2 + 35) @(negedge clock);
        check_output("mid-frame queued", count[0], 2);
        nreset = 1'b0;
        #1;
        check_output("mid reset line", line[0], 1);
        check_output("mid reset count", count[0], 0);
        check_output("mid reset busy", busy[0], 0);
        repeat (2) @(negedge clock);
        nreset = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clock);
            if (line[0] !== 1'b1) low_cnt++;
        end
        check_output("post reset idle line", low_cnt, 0);
        check_output("post reset busy", busy[0], 0);
        check_output("post reset rx frames", rxq.size(), 0);
        push_byte(0, 8'h5A, ed);
        wait_rx(1);
        if (rxq.size() > 0) check_output("post reset new byte", rxq[0], 8'h5A);
        repeat (20) @(negedge clock);

        // Random loopback with random producer gaps.
        rxq.delete();
        for (int i = 0; i < 256; i++) begin
            rb = 8'($urandom_range(0, 255));
            sent.push_back(rb);
            push_byte(0, rb, ed);
            repeat ($urandom_range(0, 30)) @(negedge clock);
        end
        wait_rx(256);
        for (int i = 0; i < 256 && i < rxq.size(); i++)
            check_output($sformatf("loopback %0d", i), rxq[i], sent[i]);
        check_output("receiver framing errors", rx_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
